// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Data-memory responder for the core's M-stage port. Word-organised
//            RAM with byte-lane stores and sign/zero-extended sub-word loads,
//            plus a small MMIO window (GPIO, cycle counter, error status).
//            Loads are combinational; stores commit at the rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memen,
  input  logic        memwrite,
  input  logic [2:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [15:0] gpio_out,
  output logic        err,
  output logic [31:0] err_addr
);

  localparam logic [1:0] C_SZ_WORD = 2'b00;
  localparam logic [1:0] C_SZ_HALF = 2'b01;
  localparam logic [1:0] C_SZ_BYTE = 2'b10;
  localparam logic [1:0] C_OFF_GPIO   = 2'b00;
  localparam logic [1:0] C_OFF_CYCLE  = 2'b01;
  localparam logic [1:0] C_OFF_STATUS = 2'b10;

  logic [31:0]       mem_q [2**ADDR_W];
  logic [15:0]       gpio_q, gpio_d;
  logic [31:0]       cycle_q, cycle_d;
  logic              err_q, err_d;
  logic [31:0]       err_addr_q, err_addr_d;

  logic [1:0]        w_size;
  logic              w_is_mmio;
  logic              w_fault;
  logic              w_acc_ok;
  logic              w_ram_we;
  logic [3:0]        w_be;
  logic [31:0]       w_lane_wd;
  logic [ADDR_W-1:0] w_idx;
  logic [31:0]       w_ram_word;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_ram_load;
  logic [31:0]       w_mmio_load;

  assign w_size     = mem_op[1:0];
  assign w_is_mmio  = (addr[31:4] == MMIO_BASE[31:4]);
  assign w_idx      = addr[ADDR_W+1:2];
  assign w_ram_word = mem_q[w_idx];

  // Access legality: reserved size, misaligned half/word, or sub-word MMIO access.
  always_comb begin
    w_fault = 1'b0;
    if (memen) begin
      w_fault = (w_size == 2'b11)
              | ((w_size == C_SZ_HALF) & addr[0])
              | ((w_size == C_SZ_WORD) & (addr[1:0] != 2'b00))
              | (w_is_mmio & (w_size != C_SZ_WORD));
    end
  end

  assign w_acc_ok = memen & ~w_fault;
  // RAM store is dropped in a reset cycle.
  assign w_ram_we = w_acc_ok & memwrite & ~w_is_mmio & ~rst;

  // Byte enables and lane-replicated store data from size and address.
  always_comb begin
    w_be      = 4'b0000;
    w_lane_wd = writedata;
    case (w_size)
      C_SZ_WORD: begin
        w_be      = 4'b1111;
        w_lane_wd = writedata;
      end
      C_SZ_HALF: begin
        w_be      = addr[1] ? 4'b1100 : 4'b0011;
        w_lane_wd = {2{writedata[15:0]}};
      end
      C_SZ_BYTE: begin
        w_be      = 4'b0001 << addr[1:0];
        w_lane_wd = {4{writedata[7:0]}};
      end
      default: begin
        w_be      = 4'b0000;
        w_lane_wd = writedata;
      end
    endcase
  end

  // RAM byte-lane write; contents are deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (w_ram_we && w_be[k]) begin
        mem_q[w_idx][8*k +: 8] <= w_lane_wd[8*k +: 8];
      end
    end
  end

  // Load lane selection and sign/zero extension from RAM.
  always_comb begin
    w_byte = w_ram_word[8*addr[1:0] +: 8];
    w_half = addr[1] ? w_ram_word[31:16] : w_ram_word[15:0];
    case (w_size)
      C_SZ_HALF: w_ram_load = mem_op[2] ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      C_SZ_BYTE: w_ram_load = mem_op[2] ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      default:   w_ram_load = w_ram_word;
    endcase
  end

  // MMIO register read mux (word offsets 0x0..0xC).
  always_comb begin
    case (addr[3:2])
      C_OFF_GPIO:   w_mmio_load = {16'h0, gpio_q};
      C_OFF_CYCLE:  w_mmio_load = cycle_q;
      C_OFF_STATUS: w_mmio_load = {31'h0, err_q};
      default:      w_mmio_load = err_addr_q;
    endcase
  end

  assign readdata = (w_acc_ok & ~memwrite) ? (w_is_mmio ? w_mmio_load : w_ram_load) : 32'h0;

  // Next-state for MMIO registers: GPIO write, free-running counter, sticky error.
  always_comb begin
    gpio_d     = gpio_q;
    cycle_d    = cycle_q + 32'd1;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    if (w_acc_ok && memwrite && w_is_mmio) begin
      if (addr[3:2] == C_OFF_GPIO) begin
        gpio_d = writedata[15:0];
      end
      if ((addr[3:2] == C_OFF_STATUS) && writedata[0]) begin
        err_d = 1'b0;
      end
    end
    if (w_fault) begin
      err_d = 1'b1;
      if (!err_q) begin
        err_addr_d = addr;
      end
    end
  end

  // MMIO state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_q     <= 16'h0;
      cycle_q    <= 32'h0;
      err_q      <= 1'b0;
      err_addr_q <= 32'h0;
    end else begin
      gpio_q     <= gpio_d;
      cycle_q    <= cycle_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign gpio_out = gpio_q;
  assign err      = err_q;
  assign err_addr = err_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Purpose  : Directed self-checking bench for dmem_responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  localparam logic [31:0] C_MMIO = 32'hFFFF_0000;
  localparam logic [2:0]  C_LW  = 3'b000;
  localparam logic [2:0]  C_LH  = 3'b001;
  localparam logic [2:0]  C_LB  = 3'b010;
  localparam logic [2:0]  C_LHU = 3'b101;
  localparam logic [2:0]  C_LBU = 3'b110;

  logic        clk = 1'b0;
  logic        rst;
  logic        memen;
  logic        memwrite;
  logic [2:0]  mem_op;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [15:0] gpio_out;
  logic        err;
  logic [31:0] err_addr;

  int n_checks = 0;
  int n_fails  = 0;

  dmem_responder #(.ADDR_W(10), .MMIO_BASE(32'hFFFF_0000)) dut (
    .clk       (clk),
    .rst       (rst),
    .memen     (memen),
    .memwrite  (memwrite),
    .mem_op    (mem_op),
    .addr      (addr),
    .writedata (writedata),
    .readdata  (readdata),
    .gpio_out  (gpio_out),
    .err       (err),
    .err_addr  (err_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Present one access at the falling edge; combinational result is valid #1 later.
  task automatic acc(input logic en, input logic we, input logic [2:0] op,
                     input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    memen = en; memwrite = we; mem_op = op; addr = a; writedata = wd;
    #1;
  endtask

  task automatic idle();
    acc(1'b0, 1'b0, C_LW, 32'h0, 32'h0);
  endtask

  initial begin
    rst = 1'b1; memen = 1'b0; memwrite = 1'b0; mem_op = 3'b0; addr = 32'h0; writedata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gpio", {16'h0, gpio_out}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_err_addr", err_addr, 32'h0);
    chk("rst_readdata_idle", readdata, 32'h0);
    @(negedge clk); rst = 1'b0;

    // Word store then word/sub-word loads.
    acc(1, 1, C_LW, 32'h10, 32'h1234_5678);
    acc(1, 0, C_LW, 32'h10, 32'h0);   chk("lw_10", readdata, 32'h1234_5678);
    acc(1, 0, C_LB, 32'h13, 32'h0);   chk("lb_13", readdata, 32'h0000_0012);
    acc(1, 0, C_LBU, 32'h11, 32'h0);  chk("lbu_11", readdata, 32'h0000_0056);

    // Sign vs zero extension.
    acc(1, 1, C_LW, 32'h20, 32'h0000_80FF);
    acc(1, 0, C_LB, 32'h20, 32'h0);   chk("lb_20", readdata, 32'hFFFF_FFFF);
    acc(1, 0, C_LH, 32'h20, 32'h0);   chk("lh_20", readdata, 32'hFFFF_80FF);
    acc(1, 0, C_LHU, 32'h20, 32'h0);  chk("lhu_20", readdata, 32'h0000_80FF);
    acc(1, 0, C_LBU, 32'h21, 32'h0);  chk("lbu_21", readdata, 32'h0000_0080);

    // Byte/half lane merges; upper store-data bits must not leak.
    acc(1, 1, C_LW, 32'h30, 32'hAABB_CCDD);
    acc(1, 1, C_LB, 32'h31, 32'hFFFF_FF11);
    acc(1, 1, C_LH, 32'h32, 32'h9999_2233);
    acc(1, 0, C_LW, 32'h30, 32'h0);   chk("merge_30", readdata, 32'h2233_11DD);
    acc(1, 0, C_LH, 32'h32, 32'h0);   chk("lh_32", readdata, 32'h0000_2233);
    chk("no_err_yet", {31'h0, err}, 32'h0);

    // Misaligned half store: no write, first fault captured.
    acc(1, 1, C_LW, 32'h40, 32'h5566_7788);
    acc(1, 1, C_LH, 32'h41, 32'h0000_FFFF);
    idle();
    chk("fault_err", {31'h0, err}, 32'h1);
    chk("fault_err_addr", err_addr, 32'h41);
    acc(1, 0, C_LW, 32'h40, 32'h0);   chk("fault_no_write", readdata, 32'h5566_7788);
    acc(1, 0, C_LW, 32'h46, 32'h0);   chk("fault_load_rd0", readdata, 32'h0);
    idle();
    chk("err_addr_held", err_addr, 32'h41);
    acc(1, 0, C_LW, C_MMIO + 32'h8, 32'h0);  chk("status_rd", readdata, 32'h1);
    acc(1, 0, C_LW, C_MMIO + 32'hC, 32'h0);  chk("erraddr_rd", readdata, 32'h41);
    acc(1, 1, C_LW, C_MMIO + 32'h8, 32'h1);
    idle();
    chk("w1c_err", {31'h0, err}, 32'h0);
    acc(1, 1, C_LW, 32'h43, 32'h0);  // new fault after clear recaptures
    idle();
    chk("refault_addr", err_addr, 32'h43);

    // Reset, then count idle cycles.
    @(negedge clk); rst = 1'b1; memen = 1'b0;
    @(negedge clk); rst = 1'b0;
    chk("rst2_err_addr", err_addr, 32'h0);
    repeat (5) @(posedge clk);
    acc(1, 0, C_LW, C_MMIO + 32'h4, 32'h0);  chk("cycle_5", readdata, 32'd5);

    // GPIO write/read; sub-word MMIO access faults and is ignored.
    acc(1, 1, C_LW, C_MMIO, 32'h1234_ABCD);
    idle();
    chk("gpio_out", {16'h0, gpio_out}, 32'h0000_ABCD);
    acc(1, 0, C_LW, C_MMIO, 32'h0);   chk("gpio_rd", readdata, 32'h0000_ABCD);
    acc(1, 1, C_LB, C_MMIO, 32'h0000_0055);
    idle();
    chk("mmio_sb_err", {31'h0, err}, 32'h1);
    chk("mmio_sb_addr", err_addr, C_MMIO);
    chk("mmio_sb_gpio", {16'h0, gpio_out}, 32'h0000_ABCD);

    // Store in a reset cycle is dropped.
    acc(1, 1, C_LW, 32'h50, 32'h0);
    @(negedge clk); rst = 1'b1; memen = 1'b1; memwrite = 1'b1; mem_op = C_LW; addr = 32'h50; writedata = 32'h1;
    @(negedge clk); rst = 1'b0; memen = 1'b0; memwrite = 1'b0;
    acc(1, 0, C_LW, 32'h50, 32'h0);   chk("rst_store_drop", readdata, 32'h0);
    chk("rst3_err", {31'h0, err}, 32'h0);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
